// File: rtl/board_io_pkg.sv
// Shared board-level constants and types for the DE2 input conditioning path.
package board_io_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEBOUNCE_1MS = CLK_HZ / 1000;

    localparam int KEY_W = 4;
    localparam int SW_W  = 18;

    // Idle levels: KEYs are active-low pushbuttons, SW sliders idle low.
    localparam logic [KEY_W-1:0] KEY_IDLE = '1;
    localparam logic [SW_W-1:0]  SW_IDLE  = '0;

    // Per-bit debouncer state.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter, accept FSM and
// registered rise/fall pulses.
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter logic RESET_BIT       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_r;
    logic             s2_r;
    logic             clean_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;
    db_state_e        state_r;

    // Synchronise, then accept a new level only after it has held long enough.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_r    <= RESET_BIT;
            s2_r    <= RESET_BIT;
            clean_r <= RESET_BIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_STABLE;
        end else begin
            s1_r   <= raw;
            s2_r   <= s1_r;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                ST_STABLE: begin
                    cnt_r <= CNT_ZERO;
                    if (s2_r != clean_r) begin
                        state_r <= ST_PENDING;
                    end else begin
                        state_r <= ST_STABLE;
                    end
                end
                ST_PENDING: begin
                    if (s2_r == clean_r) begin
                        // Bounced back before the hold time: drop it silently.
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_STABLE;
                    end else if (cnt_r == CNT_LAST) begin
                        clean_r <= s2_r;
                        rise_r  <= s2_r;
                        fall_r  <= ~s2_r;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_STABLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_PENDING;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= ST_STABLE;
                end
            endcase
        end
    end

    assign clean = clean_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces a group of raw board inputs, one independent
// debouncer per bit, ahead of the Nios II PIO exports.
module input_conditioner
    import board_io_pkg::*;
#(
    parameter int                N_BITS          = KEY_W,
    parameter int                DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter logic [N_BITS-1:0] RESET_VAL       = {N_BITS{1'b1}}
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_BITS-1:0] raw_in,
    output logic [N_BITS-1:0] clean_out,
    output logic [N_BITS-1:0] rise_pulse,
    output logic [N_BITS-1:0] fall_pulse
);

    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[i])
        ) u_debounce_bit (
            .clk     (clk_clk),
            .reset_n (reset_reset_n),
            .raw     (raw_in[i]),
            .clean   (clean_out[i]),
            .rise    (rise_pulse[i]),
            .fall    (fall_pulse[i])
        );
    end

endmodule
